// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexed hex driver for common-anode 7-segment displays.
// Digit data is double-buffered and committed only at a frame boundary, so a
// frame never shows a mix of old and new digits.
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   load        one-cycle strobe capturing data_in / blank_in
//   data_in     packed nibbles, digit 0 in bits [3:0]
//   blank_in    per-digit blank mask (1 = dark)
//   seg         active-low segments {g,f,e,d,c,b,a}
//   an          active-low anode enables, at most one low
//   frame_done  one-cycle pulse when the scan wraps to digit 0
// Optional build macro: SEG_MUX_DEADTIME_EN keeps every digit dark for the
// first DEAD_CYCLES counts of its slot to hide anode-driver ghosting.
module seven_seg_mux #(
    parameter int NUM_DIGITS  = 2,
    parameter int REFRESH_DIV = 10000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

`ifdef SEG_MUX_DEADTIME_EN
    localparam bit DEAD_EN = 1'b1;
`else
    localparam bit DEAD_EN = 1'b0;
`endif

    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic                    r_pend_valid;
    logic [4*NUM_DIGITS-1:0] r_act_data;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_tick;
    logic                    w_boundary;
    logic                    w_dead;
    logic                    w_dark;
    logic [3:0]              w_nib;
    logic [6:0]              w_dec;
    logic [NUM_DIGITS-1:0]   w_an;

    assign w_tick     = (r_cnt == CNT_MAX);
    assign w_boundary = w_tick && (r_idx == IDX_MAX);

    // Constant-folds away entirely when the dead-time build is not selected.
    assign w_dead = DEAD_EN && (int'(r_cnt) < DEAD_CYCLES);
    assign w_dark = r_act_blank[r_idx] || w_dead;
    assign w_nib  = r_act_data[4*int'(r_idx) +: 4];
    assign w_an   = ~(NUM_DIGITS'(1) << r_idx);

    always_comb begin
        w_dec = 7'h7F;
        unique case (w_nib)
            4'h0: w_dec = 7'h40;
            4'h1: w_dec = 7'h79;
            4'h2: w_dec = 7'h24;
            4'h3: w_dec = 7'h30;
            4'h4: w_dec = 7'h19;
            4'h5: w_dec = 7'h12;
            4'h6: w_dec = 7'h02;
            4'h7: w_dec = 7'h78;
            4'h8: w_dec = 7'h00;
            4'h9: w_dec = 7'h10;
            4'hA: w_dec = 7'h08;
            4'hB: w_dec = 7'h03;
            4'hC: w_dec = 7'h46;
            4'hD: w_dec = 7'h21;
            4'hE: w_dec = 7'h06;
            4'hF: w_dec = 7'h0E;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pend_data  <= '0;
            r_pend_blank <= '1;
            r_pend_valid <= 1'b0;
            r_act_data   <= '0;
            r_act_blank  <= '1;
            r_seg        <= 7'h7F;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_tick ? '0 : r_cnt + CW'(1);
            r_frame_done <= w_boundary;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
            end
            // A load landing on the boundary bypasses the pending buffer.
            if (w_boundary) begin
                if (load) begin
                    r_act_data  <= data_in;
                    r_act_blank <= blank_in;
                end else if (r_pend_valid) begin
                    r_act_data  <= r_pend_data;
                    r_act_blank <= r_pend_blank;
                end
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pend_data  <= data_in;
                r_pend_blank <= blank_in;
                r_pend_valid <= 1'b1;
            end
            if (w_dark) begin
                r_seg <= 7'h7F;
                r_an  <= '1;
            end else begin
                r_seg <= w_dec;
                r_an  <= w_an;
            end
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: directed self-checking bench for seven_seg_mux
// (NUM_DIGITS=2, REFRESH_DIV=4, DEAD_CYCLES=1).
module tb_seven_seg_mux;

    localparam int ND = 2;
    localparam int RD = 4;
    localparam int DC = 1;

`ifdef SEG_MUX_DEADTIME_EN
    localparam bit DEAD = 1'b1;
`else
    localparam bit DEAD = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       load     = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic [1:0] blank_in = 2'b00;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    // k = number of rising edges since reset was released
    int k = 0;

    always #5 clk = ~clk;

    seven_seg_mux #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .data_in   (data_in),
        .blank_in  (blank_in),
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done)
    );

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        k     = 0;
    endtask

    task automatic pulse_load(input logic [7:0] d, input logic [1:0] b);
        load     = 1'b1;
        data_in  = d;
        blank_in = b;
        step();
        load = 1'b0;
    endtask

    // Expected outputs seen after edge kk: they reflect the counter/index
    // state left by edge kk-1.
    function automatic void model(input int kk,
                                  input logic [6:0] s0,
                                  input logic [6:0] s1,
                                  input logic [1:0] blk,
                                  output logic [6:0] es,
                                  output logic [1:0] ea);
        int s;
        int c;
        int i;
        s  = kk - 1;
        c  = s % RD;
        i  = (s / RD) % ND;
        es = 7'h7F;
        ea = 2'b11;
        if (!blk[i] && !(DEAD && c < DC)) begin
            ea = (i == 0) ? 2'b10 : 2'b01;
            es = (i == 0) ? s0 : s1;
        end
    endfunction

    task automatic test_reset();
        reset    = 1'b1;
        load     = 1'b1;
        data_in  = 8'h88;
        blank_in = 2'b00;
        repeat (3) @(negedge clk);
        n_tests++;
        if (seg !== 7'h7F || an !== 2'b11 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold seg=%h an=%b fd=%b want 7f 11 0",
                     seg, an, frame_done);
        end
        load  = 1'b0;
        reset = 1'b0;
        k     = 0;
        while (k < 16) begin
            step();
            n_tests++;
            if (seg !== 7'h7F || an !== 2'b11) begin
                n_fail++;
                $display("FAIL reset_dark k=%0d seg=%h an=%b want 7f 11",
                         k, seg, an);
            end
            n_tests++;
            if (frame_done !== (k % 8 == 0)) begin
                n_fail++;
                $display("FAIL reset_fd k=%0d fd=%b want %b",
                         k, frame_done, (k % 8 == 0));
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [6:0] es;
        logic [1:0] ea;
        do_reset();
        step();
        pulse_load(8'h3A, 2'b00);
        while (k < 24) begin
            step();
            if (k <= 8) begin
                es = 7'h7F;
                ea = 2'b11;
            end else begin
                model(k, 7'h08, 7'h30, 2'b00, es, ea);
            end
            n_tests++;
            if (seg !== es || an !== ea) begin
                n_fail++;
                $display("FAIL basic k=%0d seg=%h an=%b want %h %b",
                         k, seg, an, es, ea);
            end
            if (k % 8 == 0) begin
                n_tests++;
                if (frame_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_fd k=%0d fd=%b want 1", k, frame_done);
                end
            end
        end
    endtask

    task automatic test_frame_integrity();
        logic [6:0] es;
        logic [1:0] ea;
        do_reset();
        step();
        pulse_load(8'h99, 2'b00);
        pulse_load(8'h12, 2'b00);
        while (k < 24) begin
            if (k == 10) begin
                load     = 1'b1;
                data_in  = 8'hEF;
                blank_in = 2'b00;
            end
            step();
            load = 1'b0;
            if (k >= 9) begin
                if (k <= 16) model(k, 7'h24, 7'h79, 2'b00, es, ea);
                else         model(k, 7'h0E, 7'h06, 2'b00, es, ea);
                n_tests++;
                if (seg !== es || an !== ea) begin
                    n_fail++;
                    $display("FAIL frame k=%0d seg=%h an=%b want %h %b",
                             k, seg, an, es, ea);
                end
            end
        end
    endtask

    task automatic test_bypass();
        logic [6:0] es;
        logic [1:0] ea;
        do_reset();
        step();
        pulse_load(8'hFF, 2'b00);
        while (k < 24) begin
            if (k == 7) begin
                load     = 1'b1;
                data_in  = 8'h05;
                blank_in = 2'b10;
            end
            step();
            load = 1'b0;
            if (k <= 8) begin
                es = 7'h7F;
                ea = 2'b11;
            end else begin
                model(k, 7'h12, 7'h7F, 2'b10, es, ea);
            end
            n_tests++;
            if (seg !== es || an !== ea) begin
                n_fail++;
                $display("FAIL bypass k=%0d seg=%h an=%b want %h %b",
                         k, seg, an, es, ea);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step();
        pulse_load(8'h3A, 2'b00);
        while (k < 14) step();
        n_tests++;
        if (seg !== 7'h30 || an !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_pre seg=%h an=%b want 30 01", seg, an);
        end
        reset = 1'b1;
        step();
        n_tests++;
        if (seg !== 7'h7F || an !== 2'b11 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_dark seg=%h an=%b fd=%b want 7f 11 0",
                     seg, an, frame_done);
        end
        reset = 1'b0;
        k     = 0;
        while (k < 8) begin
            step();
            n_tests++;
            if (frame_done !== (k == 8) || seg !== 7'h7F || an !== 2'b11) begin
                n_fail++;
                $display("FAIL midrst_run k=%0d fd=%b seg=%h an=%b want %b 7f 11",
                         k, frame_done, seg, an, (k == 8));
            end
        end
    endtask

    task automatic test_dead_time();
        logic [6:0] es;
        logic [1:0] ea;
        do_reset();
        step();
        pulse_load(8'h88, 2'b00);
        while (k < 24) begin
            step();
            if (k >= 9) begin
                model(k, 7'h00, 7'h00, 2'b00, es, ea);
                n_tests++;
                if (seg !== es || an !== ea) begin
                    n_fail++;
                    $display("FAIL dead k=%0d seg=%h an=%b want %h %b",
                             k, seg, an, es, ea);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_frame_integrity();
        test_bypass();
        test_mid_reset();
        test_dead_time();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_mux.md
# seven_seg_mux

Time-multiplexed, parametrised hexadecimal driver for multi-digit common-anode seven-segment displays. It succeeds the single-digit combinational decoder. It accepts a packed nibble per digit plus a per-digit blank mask, and double-buffers them so a display frame never tears. It scans one digit at a time at a programmable refresh rate. It sits between the switch/user logic and the board's segment and anode pins, clocked from the system oscillator.

## Interface
- NUM_DIGITS, 2: number of digits scanned; legal range 1–8.
- REFRESH_DIV, 10000: clock cycles each digit is enabled; must be at least 2.
- DEAD_CYCLES, 16: blanking cycles at the start of each digit slot; used only with SEG_MUX_DEADTIME_EN; must be below REFRESH_DIV.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  single-cycle strobe; captures data_in and blank_in.
- data_in  in  4*NUM_DIGITS  hex nibble per digit; digit 0 is bits [3:0].
- blank_in  in  NUM_DIGITS  1 = digit k dark.
- seg  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- an  out  NUM_DIGITS  active-low anode enables; at most one bit low at any time.
- frame_done  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- **Registers**
  - Refresh counter: width $clog2(REFRESH_DIV). Counts 0 to REFRESH_DIV-1, then wraps to 0.
  - tick: asserted when counter == REFRESH_DIV-1.
  - Digit index: width max(1, $clog2(NUM_DIGITS)). Advances on tick and wraps from NUM_DIGITS-1 to 0.
  - Pending buffer: {data, blank, valid}.
  - Active buffer: {data, blank}.
- **Load**
  - load=1 writes data_in/blank_in into the pending buffer and sets valid. A later load overwrites earlier pending data; the last load wins.
- **Commit (frame boundary)**
  - A boundary is a tick while index == NUM_DIGITS-1.
  - If load is asserted on the boundary cycle, active takes data_in/blank_in directly (bypass) and pending valid clears.
  - Otherwise, if pending valid is set, active takes pending and valid clears.
  - Otherwise active holds.
- **Decode**
  - Active-low, bit order gfedcba:
    - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
    - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- **Outputs**
  - A non-blank digit drives an[index]=0 with its decoded pattern on seg.
  - A blank digit drives an all ones and seg=7F.
- **Reset**
  - counter=0, index=0, pending valid=0.
  - Active data=0, active blank all ones.
  - seg=7F, an all ones, frame_done=0.
  - reset overrides load in the same cycle.
  - Mid-scan reset: the display goes dark on the next edge and the scan restarts at digit 0.
- **NUM_DIGITS=1**: index stays 0 and every tick is a boundary.

## Timing
- Index and frame_done update on the clock edge where tick=1.
- seg/an are registered from (index, active, counter), so they lag the index by exactly one clock.
- Each digit is displayed for exactly REFRESH_DIV cycles.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles.
- Load-to-display latency:
  - Minimum 2 cycles (load on boundary: active updates at that edge, outputs one edge later).
  - Maximum NUM_DIGITS*REFRESH_DIV+1 cycles.
- frame_done is high for exactly one cycle per frame, in the same cycle the index reads 0 after a wrap.
- No combinational path from inputs to outputs.

## Configuration
- **SEG_MUX_DEADTIME_EN**
  - Defined: while counter < DEAD_CYCLES in each digit slot, the registered outputs are an all ones and seg=7F. This suppresses ghosting from slow anode transistors; enabled time per digit becomes REFRESH_DIV-DEAD_CYCLES.
  - Undefined: no dead-time logic is generated and DEAD_CYCLES is ignored.
  - Frame timing, commit and frame_done are identical in both builds.

## Test plan
Bench parameters: NUM_DIGITS=2, REFRESH_DIV=4, DEAD_CYCLES=1.
- **Reset**: hold reset 3 cycles, then release with no load → seg=7F and an=2'b11 for at least 16 cycles; frame_done pulses every 8 cycles.
- **Basic scan**: load data_in=8'h3A, blank_in=00 → from the first commit on, an alternates 10 (seg=08, "A") and 01 (seg=30, "3"), 4 cycles each, with no overlap.
- **Frame integrity**: load 8'h12 and, mid-frame, 8'hEF → the displayed frame is never mixed; the next full frame shows only F,E (seg 0E, then 06).
- **Boundary bypass and blanking**: load=1 exactly on the boundary tick with data 8'h05, blank_in=10 → 2 cycles later an=10 and seg=12; digit 1 stays dark (an=11 during its slot).
- **Mid-operation reset**: assert reset during a digit-1 slot → next edge gives seg=7F and an=11; after release, first frame_done occurs 8 cycles later.
- **Dead time (macro defined)**: with 8'h88 loaded → each 4-cycle slot shows 1 cycle of an=11 then 3 cycles of seg=00; with the macro undefined, all 4 cycles are lit.
